// File: rtl/gaussian_frame_sequencer_pkg.sv
// Shared types and constants for the 3x3 Gaussian frame sequencer.
package gaussian_pkg;
  localparam int DIM_W_DEF  = 11;
  localparam int KERNEL_DIM = 3;
  localparam int MIN_DIM    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/gaussian_frame_sequencer_if.sv
// Pixel-in / window-out stream bundle between sequencer, line buffer and kernel stage.
interface gaussian_frame_sequencer_if #(parameter int DATA_W = 8) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              shift_en;
  logic [DATA_W-1:0] lb_data;
  logic              m_valid;
  logic              m_ready;

  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, shift_en, lb_data, m_valid);
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, shift_en, lb_data, m_valid);
endinterface

// File: rtl/gaussian_frame_sequencer_pos_counter.sv
// Raster row/col tracker: cur_* points at the next pixel, row/col hold the last accepted one.
module gaussian_pos_counter
  import gaussian_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             clr,
  input  logic             en,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             last,
  output logic             win
);
  logic [DIM_W-1:0] cur_row, cur_col;
  logic             col_wrap;

  assign col_wrap = (cur_col == width - DIM_W'(1));
  assign last     = col_wrap && (cur_row == height - DIM_W'(1));
  // A full 3x3 window exists once the incoming pixel is at least two rows/cols in.
  assign win      = (cur_row >= DIM_W'(KERNEL_DIM - 1)) && (cur_col >= DIM_W'(KERNEL_DIM - 1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cur_row <= '0;
      cur_col <= '0;
      row     <= '0;
      col     <= '0;
    end else if (clr) begin
      cur_row <= '0;
      cur_col <= '0;
      row     <= '0;
      col     <= '0;
    end else if (en) begin
      row <= cur_row;
      col <= cur_col;
      if (col_wrap) begin
        cur_col <= '0;
        cur_row <= cur_row + DIM_W'(1);
      end else begin
        cur_col <= cur_col + DIM_W'(1);
      end
    end
  end
endmodule

// File: rtl/gaussian_frame_sequencer.sv
// Frame sequencer for the 3x3 Gaussian datapath: config latch, raster tracking, window strobe.
// Optional backpressure counter built only when GAUSS_STALL_CNT_EN is defined.
module gaussian_frame_sequencer
  import gaussian_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int DATA_W = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [DIM_W-1:0]           cfg_width,
  input  logic [DIM_W-1:0]           cfg_height,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  gaussian_frame_sequencer_if.slave  pix,
  output logic [DIM_W-1:0]           row,
  output logic [DIM_W-1:0]           col,
  output logic [31:0]                stall_cnt
);
  seq_state_t        state, state_nxt;
  logic [DIM_W-1:0]  cfg_w, cfg_h;
  logic              mv, s_ready, shift_en, start_acc, cfg_bad, last, win;
  logic [DATA_W-1:0] fwd;

  assign start_acc = (state == IDLE) && start;
  assign cfg_bad   = (cfg_width < DIM_W'(MIN_DIM)) || (cfg_height < DIM_W'(MIN_DIM));
  assign shift_en  = pix.s_valid && s_ready;
  assign fwd       = pix.s_data;

  assign pix.s_ready  = s_ready;
  assign pix.shift_en = shift_en;
  assign pix.lb_data  = fwd;
  assign pix.m_valid  = mv;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start_acc) state_nxt = cfg_bad ? DONE : RUN;
      RUN: begin
        busy    = 1'b1;
        s_ready = !mv || pix.m_ready;
        if (shift_en && last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!mv || pix.m_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cfg_w <= '0;
      cfg_h <= '0;
      err   <= 1'b0;
    end else if (start_acc) begin
      cfg_w <= cfg_width;
      cfg_h <= cfg_height;
      err   <= cfg_bad;
    end
  end

  // Single output register: a new window accept wins over a same-cycle drain.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                mv <= 1'b0;
    else if (shift_en && win)  mv <= 1'b1;
    else if (pix.m_ready)      mv <= 1'b0;
  end

  gaussian_pos_counter #(.DIM_W(DIM_W)) u_pos (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .clr    (start_acc),
    .en     (shift_en),
    .width  (cfg_w),
    .height (cfg_h),
    .row    (row),
    .col    (col),
    .last   (last),
    .win    (win)
  );

`ifdef GAUSS_STALL_CNT_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      stall_cnt <= '0;
    else if (start_acc)
      stall_cnt <= '0;
    else if (busy && mv && !pix.m_ready && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule
